// File: rtl/comb_sweep_gen.sv
`default_nettype none
// ============================================================================
// Module  : comb_sweep_gen
// Purpose : Applies every 2^IN_W input vector to a combinational block and
//           folds the sampled responses into a MISR signature. Define
//           COMB_SWEEP_GOLDEN_EN to add expected-response mismatch tracking.
// Revision: 1.0 - initial release
// ============================================================================
module comb_sweep_gen #(
    parameter int              IN_W   = 4,
    parameter int              OUT_W  = 1,
    parameter int              SETTLE = 1,
    parameter int              SIG_W  = 16,
    parameter logic [SIG_W-1:0] POLY  = 16'h1021,
    parameter logic [SIG_W-1:0] SEED  = 16'h0000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic [IN_W-1:0]  a,
    input  logic [OUT_W-1:0] y,
    output logic [IN_W-1:0]  vn,
    output logic             busy,
    output logic             done,
    output logic [SIG_W-1:0] signature
`ifdef COMB_SWEEP_GOLDEN_EN
    ,
    input  logic [OUT_W-1:0] yeta,
    output logic [15:0]      err_count,
    output logic [IN_W-1:0]  first_fail
`endif
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_SAMPLE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    localparam logic [IN_W-1:0] C_A_LAST   = '1;
    localparam logic [7:0]      C_CNT_INIT = 8'(SETTLE - 1);

    state_t           state_q;
    logic [IN_W-1:0]  a_q;
    logic [7:0]       cnt_q;
    logic             busy_q;
    logic             done_q;
    logic [SIG_W-1:0] sig_q;
    logic [SIG_W-1:0] sig_d;

    // Shift-left MISR step with polynomial feedback on the outgoing MSB.
    always_comb begin
        sig_d = {sig_q[SIG_W-2:0], 1'b0}
              ^ (sig_q[SIG_W-1] ? POLY : {SIG_W{1'b0}})
              ^ SIG_W'(y);
    end

`ifdef COMB_SWEEP_GOLDEN_EN
    logic [15:0]     err_q;
    logic [IN_W-1:0] ff_q;
    logic            w_mismatch;

    assign w_mismatch = (y != yeta);
    assign err_count  = err_q;
    assign first_fail = ff_q;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sig_q   <= SEED;
`ifdef COMB_SWEEP_GOLDEN_EN
            err_q   <= '0;
            ff_q    <= '0;
`endif
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        a_q     <= '0;
                        sig_q   <= SEED;
                        done_q  <= 1'b0;
                        busy_q  <= 1'b1;
                        cnt_q   <= C_CNT_INIT;
                        state_q <= S_WAIT;
`ifdef COMB_SWEEP_GOLDEN_EN
                        err_q   <= '0;
                        ff_q    <= '0;
`endif
                    end
                end
                S_WAIT: begin
                    if (cnt_q == 8'd0) begin
                        state_q <= S_SAMPLE;
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end
                S_SAMPLE: begin
                    sig_q <= sig_d;
`ifdef COMB_SWEEP_GOLDEN_EN
                    if (w_mismatch) begin
                        if (err_q != 16'hFFFF) begin
                            err_q <= err_q + 16'd1;
                        end
                        if (err_q == 16'd0) begin
                            ff_q <= a_q;
                        end
                    end
`endif
                    if (a_q == C_A_LAST) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        a_q     <= a_q + 1'b1;
                        cnt_q   <= C_CNT_INIT;
                        state_q <= S_WAIT;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign a         = a_q;
    assign vn        = a_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign signature = sig_q;

endmodule
`default_nettype wire
